blend_writer: RTL and testbench
===============================

// Module: blend_writer
// PURPOSE
//  Downstream stage of the homography sync controller. Takes each validated pixel
//  pair (DVI source pixel plus warped CCD pixel at the same sync_x/sync_y) and
//  alpha-blends the two RGB565 values, with optional black-key pass-through.
//  Buffers results in a small FIFO and writes them to the frame-buffer write port
//  over a req/ack handshake. Flags dropped pixels and signals end of frame.
// PARAMETERS
//  H_ACTIVE    640  active pixels per line; sync_x >= H_ACTIVE is out of range
//  V_ACTIVE    480  active lines per frame; sync_y >= V_ACTIVE is out of range
//  FIFO_DEPTH  8    blended-word FIFO entries (power of 2, >= 2)
//  KEY_EN      1    1: CCD pixel 16'h0000 passes the DVI pixel through unblended
// PORTS
//  clk_25      in   1   system clock; all logic on posedge
//  rst_n       in   1   asynchronous active-low reset
//  val         in   1   one-cycle strobe: sync_x/sync_y/dvi_*/ccd_* valid this cycle
//  sync_x      in   10  pixel column
//  sync_y      in   10  pixel row
//  dvi_r/g/b   in   5/6/5  source pixel
//  ccd_r/g/b   in   5/6/5  warped camera pixel
//  alpha       in   5   CCD weight 0..16, sampled with val; values >16 clamp to 16
//  wr_addr     out  19  frame-buffer word address = sync_y*H_ACTIVE + sync_x
//  wr_data     out  16  blended RGB565 {r[4:0], g[5:0], b[4:0]}
//  wr_req      out  1   write request; held high until wr_ack
//  wr_ack      in   1   frame buffer accepts wr_addr/wr_data this cycle
//  overflow    out  1   sticky: an in-range pixel was dropped on a full FIFO
//  frame_done  out  1   one-cycle pulse on ack of pixel (H_ACTIVE-1, V_ACTIVE-1)
// BEHAVIOUR
//  Reset: wr_addr=0, wr_data=0, wr_req=0, overflow=0, frame_done=0; FIFO empty;
//   blend stage invalid; FSM in W_IDLE. Reset mid-transfer abandons the word.
//  Blend stage (registered, 1 cycle): a = min(alpha,16); per channel
//   out = (a*ccd + (16-a)*dvi + 8) >> 4. Intermediates: 9 bits for r/b,
//   10 bits for g. Result never exceeds 31/63.
//   KEY_EN=1 and {ccd_r,ccd_g,ccd_b}==0: out = dvi, regardless of alpha.
//   Address is computed in the same stage, unsigned, 19 bits.
//  Range filter: val with sync_x>=H_ACTIVE or sync_y>=V_ACTIVE is discarded
//   silently; no push, no overflow.
//  FIFO push: on the edge after the blend stage holds a valid in-range word
//   (val at edge N -> word in FIFO at edge N+1).
//   Full with no pop that cycle: drop the word and set overflow until reset.
//   Full with a pop in the same cycle: push accepted, no drop.
//  Write FSM:
//   W_IDLE: FIFO non-empty -> load head into wr_addr/wr_data, pop it,
//    assert wr_req, go to W_REQ. Earliest wr_req: after edge N+2.
//   W_REQ: wr_req=1; wr_addr/wr_data stable.
//    On wr_ack with FIFO non-empty: load the next head and pop it in the same
//     cycle, stay in W_REQ (back-to-back, 1 word/cycle).
//    On wr_ack with FIFO empty: wr_req=0, go to W_IDLE.
//   wr_ack while wr_req=0 is ignored.
//  frame_done: asserted the cycle after the wr_ack of the word whose address is
//   H_ACTIVE*V_ACTIVE-1.
//  Pixel order through the block is preserved exactly; no reordering, no merging.
// TESTING
//  1 alpha=16, ccd=(31,0,0), dvi=(0,63,0), x=3, y=2, ack tied high
//    -> wr_data=16'hF800, wr_addr=1283, wr_req first high 2 cycles after val.
//  2 alpha=8, ccd=(31,63,31), dvi=0 -> wr_data={5'd16,6'd32,5'd16};
//    alpha=20 behaves as 16; alpha=0 -> wr_data equals dvi.
//  3 KEY_EN=1, ccd=0, dvi=(10,20,30), alpha=16 -> wr_data={5'd10,6'd20,5'd30}.
//  4 wr_ack held low, 12 consecutive val -> wr_req holds the first word stable;
//    overflow rises on pixel 10 (1 held + 8 queued + 1 in blend); after ack
//    released, exactly 9 words emerge in order.
//  5 val with x=640 or y=480 -> no write, overflow stays 0;
//    pixel (639,479) acked -> frame_done pulses once, wr_addr=307199.
//  6 rst_n low while wr_req=1 with FIFO holding 3 words
//    -> wr_req=0 immediately; no writes after release until new val.

Source files
------------

// File: rtl/blend_writer.sv
// Alpha-blends each validated DVI/CCD RGB565 pixel pair, queues the result and
// writes it to the frame buffer over a req/ack handshake.
module blend_writer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 8,
  parameter bit KEY_EN     = 1'b1
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        val,
  input  logic [9:0]  sync_x,
  input  logic [9:0]  sync_y,
  input  logic [4:0]  dvi_r,
  input  logic [5:0]  dvi_g,
  input  logic [4:0]  dvi_b,
  input  logic [4:0]  ccd_r,
  input  logic [5:0]  ccd_g,
  input  logic [4:0]  ccd_b,
  input  logic [4:0]  alpha,
  output logic [18:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic        overflow,
  output logic        frame_done
);

  localparam int               AW        = $clog2(FIFO_DEPTH);
  localparam logic [9:0]       H_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]       V_LIM     = 10'(V_ACTIVE);
  localparam logic [18:0]      H_ACT19   = 19'(H_ACTIVE);
  localparam logic [18:0]      LAST_ADDR = 19'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {W_IDLE, W_REQ} w_state_e;

  // Blend stage
  logic        b_valid_q, b_valid_d;
  logic [18:0] b_addr_q,  b_addr_d;
  logic [15:0] b_data_q,  b_data_d;

  logic [4:0]  a_clamp, a_inv;
  logic [8:0]  sum_r, sum_b;
  logic [9:0]  sum_g;
  logic        in_range, key_hit;

  // FIFO
  logic [34:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          fifo_empty, fifo_full, push, pop, drop;
  logic [34:0]   fifo_head;

  // Write port
  w_state_e    state_q, state_d;
  logic [18:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_req_q, wr_req_d;
  logic        overflow_q, overflow_d;
  logic        frame_done_q, frame_done_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_clamp  = (alpha > 5'd16) ? 5'd16 : alpha;
    a_inv    = 5'd16 - a_clamp;
    sum_r    = {4'd0, a_clamp} * {4'd0, ccd_r} + {4'd0, a_inv} * {4'd0, dvi_r} + 9'd8;
    sum_g    = {5'd0, a_clamp} * {4'd0, ccd_g} + {5'd0, a_inv} * {4'd0, dvi_g} + 10'd8;
    sum_b    = {4'd0, a_clamp} * {4'd0, ccd_b} + {4'd0, a_inv} * {4'd0, dvi_b} + 9'd8;
    in_range = (sync_x < H_LIM) && (sync_y < V_LIM);
    key_hit  = KEY_EN && ({ccd_r, ccd_g, ccd_b} == 16'd0);

    b_valid_d = val && in_range;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    if (b_valid_d) begin
      b_addr_d = {9'd0, sync_y} * H_ACT19 + {9'd0, sync_x};
      b_data_d = key_hit ? {dvi_r, dvi_g, dvi_b}
                         : {5'(sum_r >> 4), 6'(sum_g >> 4), 5'(sum_b >> 4)};
    end
  end

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_req_d     = wr_req_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        if (!fifo_empty) begin
          pop                    = 1'b1;
          {wr_addr_d, wr_data_d} = fifo_head;
          wr_req_d               = 1'b1;
          state_d                = W_REQ;
        end
      end
      W_REQ: begin
        if (wr_ack) begin
          frame_done_d = (wr_addr_q == LAST_ADDR);
          if (!fifo_empty) begin
            pop                    = 1'b1;
            {wr_addr_d, wr_data_d} = fifo_head;
          end else begin
            wr_req_d = 1'b0;
            state_d  = W_IDLE;
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  // A full FIFO still accepts the word when the write port pops in the same cycle.
  always_comb begin
    push       = b_valid_q && (!fifo_full || pop);
    drop       = b_valid_q && fifo_full && !pop;
    overflow_d = overflow_q | drop;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d      = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: the FIFO storage has no reset; validity is tracked by the reset pointers and count.
  always_ff @(posedge clk_25) begin
    if (push) fifo_mem[wr_ptr_q] <= {b_addr_q, b_data_q};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_q    <= 1'b0;
      b_addr_q     <= '0;
      b_data_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      state_q      <= W_IDLE;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_req_q     <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      b_valid_q    <= b_valid_d;
      b_addr_q     <= b_addr_d;
      b_data_q     <= b_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_req_q     <= wr_req_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_req     = wr_req_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_blend_writer.sv
// Directed bench for blend_writer: blend arithmetic, keying, FIFO overflow,
// range filter, end-of-frame pulse and reset during a transfer.
module tb_blend_writer;

  logic        clk_25 = 1'b0;
  logic        rst_n, val, wr_ack;
  logic [9:0]  sync_x, sync_y;
  logic [4:0]  dvi_r, dvi_b, ccd_r, ccd_b, alpha;
  logic [5:0]  dvi_g, ccd_g;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_req, overflow, frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_cnt   = 0;
  logic [18:0] got_addr[$];
  logic [15:0] got_data[$];

  blend_writer dut (
    .clk_25(clk_25), .rst_n(rst_n), .val(val), .sync_x(sync_x), .sync_y(sync_y),
    .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
    .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b), .alpha(alpha),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_req(wr_req), .wr_ack(wr_ack),
    .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk_25 = ~clk_25;

  // Handshakes and end-of-frame pulses are recorded mid-cycle.
  always @(negedge clk_25) begin
    if (rst_n && wr_req && wr_ack) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
    if (frame_done) fd_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic logic [15:0] rgb(input int r, input int g, input int b);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = r[4:0];
    g6 = g[5:0];
    b5 = b[4:0];
    return {r5, g6, b5};
  endfunction

  task automatic apply_reset();
    rst_n  = 1'b0;
    val    = 1'b0;
    wr_ack = 1'b0;
    repeat (2) @(posedge clk_25);
    @(negedge clk_25);
    rst_n = 1'b1;
    @(posedge clk_25);
    #1;
  endtask

  // Presents one val cycle; returns 1 ns after the capturing edge.
  task automatic send(input int x, input int y, input int dr, input int dg, input int db,
                      input int cr, input int cg, input int cb, input int al);
    val    = 1'b1;
    sync_x = x[9:0];
    sync_y = y[9:0];
    dvi_r  = dr[4:0]; dvi_g = dg[5:0]; dvi_b = db[4:0];
    ccd_r  = cr[4:0]; ccd_g = cg[5:0]; ccd_b = cb[4:0];
    alpha  = al[4:0];
    @(posedge clk_25);
    #1;
    val = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int cyc = 0;
    while (got_addr.size() < target && cyc < budget) begin
      @(posedge clk_25);
      #1;
      cyc++;
    end
    check(tag, got_addr.size(), target);
  endtask

  task automatic single(input string tag, input int x, input int y,
                        input int dr, input int dg, input int db,
                        input int cr, input int cg, input int cb, input int al,
                        input logic [15:0] exp_data);
    int base = got_addr.size();
    wr_ack = 1'b1;
    send(x, y, dr, dg, db, cr, cg, cb, al);
    wait_writes({tag, "_cnt"}, base + 1, 10);
    if (got_addr.size() > base) begin
      check({tag, "_addr"}, got_addr[base], 32'(y * 640 + x));
      check({tag, "_data"}, got_data[base], exp_data);
    end
    repeat (2) @(posedge clk_25);
    #1;
  endtask

  initial begin
    int base;
    int fd_base;
    sync_x = '0; sync_y = '0; alpha = '0;
    dvi_r = '0; dvi_g = '0; dvi_b = '0; ccd_r = '0; ccd_g = '0; ccd_b = '0;

    apply_reset();
    check("rst_wr_req", wr_req, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_done", frame_done, 0);

    // Full CCD weight, latency of the first write request
    wr_ack = 1'b1;
    send(3, 2, 0, 63, 0, 31, 0, 0, 16);
    @(negedge clk_25);
    check("t1_req_n", wr_req, 0);
    @(negedge clk_25);
    check("t1_req_n1", wr_req, 0);
    @(negedge clk_25);
    check("t1_req_n2", wr_req, 1);
    check("t1_addr", wr_addr, 1283);
    check("t1_data", wr_data, 16'hF800);
    @(negedge clk_25);
    check("t1_req_drop", wr_req, 0);
    @(posedge clk_25);
    #1;

    // Blend arithmetic and alpha clamping
    single("a8",   10, 0, 0, 0, 0,    31, 63, 31,  8, rgb(16, 32, 16));
    single("a20",  11, 0, 0, 0, 0,    31, 63, 31, 20, rgb(31, 63, 31));
    single("a0",   12, 0, 5, 10, 15,  31, 63, 31,  0, rgb(5, 10, 15));
    single("a4",   13, 1, 4, 8, 12,   20, 40, 10,  4, rgb(8, 16, 12));
    single("a1",   14, 1, 0, 0, 0,    31, 63, 31,  1, rgb(2, 4, 2));
    // Black key passes DVI through; a non-zero CCD pixel does not key
    single("key",  20, 3, 10, 20, 30, 0, 0, 0,    16, rgb(10, 20, 30));
    single("nokey",21, 3, 10, 20, 30, 0, 0, 1,    16, rgb(0, 0, 1));
    check("no_frame_done_yet", fd_cnt, 0);

    // Back-pressure: 12 consecutive pixels with the write port stalled
    wr_ack = 1'b0;
    base = got_addr.size();
    for (int i = 0; i < 12; i++) begin
      send(i, 5, 0, 0, 0, 0, 0, i + 1, 16);
      val = (i < 11);
      if (i == 9)  check("ovf_before", overflow, 0);
      if (i == 10) check("ovf_rise", overflow, 1);
    end
    val = 1'b0;
    repeat (3) @(posedge clk_25);
    #1;
    check("stall_req", wr_req, 1);
    check("stall_addr", wr_addr, 3200);
    check("stall_data", wr_data, 1);
    check("stall_no_writes", got_addr.size() - base, 0);
    wr_ack = 1'b1;
    wait_writes("drain_cnt", base + 9, 40);
    repeat (6) @(posedge clk_25);
    #1;
    check("drain_exact", got_addr.size() - base, 9);
    for (int k = 0; k < 9; k++) begin
      if (base + k < got_addr.size()) begin
        check($sformatf("drain_addr%0d", k), got_addr[base + k], 32'(3200 + k));
        check($sformatf("drain_data%0d", k), got_data[base + k], 32'(k + 1));
      end
    end
    check("drain_req_low", wr_req, 0);
    check("ovf_sticky", overflow, 1);

    // Range filter and end of frame
    apply_reset();
    check("ovf_cleared", overflow, 0);
    wr_ack = 1'b1;
    base = got_addr.size();
    send(640, 0, 0, 0, 0, 31, 0, 0, 16);
    send(0, 480, 0, 0, 0, 31, 0, 0, 16);
    repeat (8) @(posedge clk_25);
    #1;
    check("oor_no_write", got_addr.size() - base, 0);
    check("oor_no_ovf", overflow, 0);
    fd_base = fd_cnt;
    single("last", 639, 479, 0, 0, 0, 0, 63, 0, 16, rgb(0, 63, 0));
    repeat (3) @(posedge clk_25);
    #1;
    check("frame_done_once", fd_cnt - fd_base, 1);

    // Reset in the middle of a stalled transfer
    wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(10 + i, 1, 0, 0, 0, 1, 1, 1, 16);
      val = (i < 3);
    end
    val = 1'b0;
    repeat (6) @(posedge clk_25);
    #1;
    check("mid_req", wr_req, 1);
    check("mid_addr", wr_addr, 650);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", wr_req, 0);
    check("async_addr", wr_addr, 0);
    wr_ack = 1'b1;
    @(negedge clk_25);
    rst_n = 1'b1;
    base = got_addr.size();
    repeat (10) @(posedge clk_25);
    #1;
    check("post_rst_no_write", got_addr.size() - base, 0);
    check("post_rst_req", wr_req, 0);
    single("post_rst_new", 7, 9, 0, 0, 0, 3, 4, 5, 16, rgb(3, 4, 5));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
